// File: rtl/output_drain_arbiter.sv
// Round-robin drain of the four switch output ports into one tagged byte stream.
// Optional FCS check (XOR of all bytes before FCS) is enabled by DRAIN_FCS_CHK_EN.
module output_drain_arbiter #(
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] port0,
  input  logic [7:0] port1,
  input  logic [7:0] port2,
  input  logic [7:0] port3,
  input  logic       ready_0,
  input  logic       ready_1,
  input  logic       ready_2,
  input  logic       ready_3,
  output logic       read_0,
  output logic       read_1,
  output logic       read_2,
  output logic       read_3,
  output logic [7:0] out_data,
  output logic       out_valid,
  output logic       out_sop,
  output logic       out_eop,
  output logic [1:0] out_port,
  output logic       busy
`ifdef DRAIN_FCS_CHK_EN
  ,
  output logic       fcs_err
`endif
);

  typedef enum logic [1:0] {StIdle, StRead, StDrain, StGap} state_e;

  localparam logic [3:0] GapLast = (GAP_CYCLES == 0) ? 4'd0 : 4'(GAP_CYCLES - 1);

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [8:0] rd_cnt_q, rd_cnt_d;
  logic [3:0] gap_cnt_q, gap_cnt_d;
  logic [8:0] idx_q;
  logic [7:0] len_q;
  logic [7:0] len_eff;
  logic [7:0] port_sel;
  logic [3:0] ready_vec;
  logic [1:0] cand;
  logic       found;
  logic       rd_en, rd_last;
  logic       rd_q, last_rd_q;

  assign ready_vec = {ready_3, ready_2, ready_1, ready_0};

  always_comb begin
    port_sel = port0;
    case (gnt_q)
      2'd0: port_sel = port0;
      2'd1: port_sel = port1;
      2'd2: port_sel = port2;
      2'd3: port_sel = port3;
      default: port_sel = port0;
    endcase
  end

  // LEN is on the port during the 4th read, before it has been registered.
  assign len_eff = (rd_q && idx_q == 9'd2) ? port_sel : len_q;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    rd_cnt_d  = rd_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rd_en     = 1'b0;
    rd_last   = 1'b0;
    found     = 1'b0;
    cand      = ptr_q;
    case (state_q)
      StIdle: begin
        rd_cnt_d  = 9'd0;
        gap_cnt_d = 4'd0;
        for (int i = 0; i < 4; i++) begin
          cand = ptr_q + i[1:0];
          if (!found && ready_vec[cand]) begin
            found = 1'b1;
            gnt_d = cand;
          end
        end
        if (found) state_d = StRead;
      end
      StRead: begin
        rd_en    = 1'b1;
        rd_cnt_d = rd_cnt_q + 9'd1;
        if (rd_cnt_q >= 9'd3 && rd_cnt_d == ({1'b0, len_eff} + 9'd4)) begin
          rd_last = 1'b1;
          ptr_d   = gnt_q + 2'd1;
          state_d = StDrain;
        end
      end
      StDrain: begin
        state_d = (GAP_CYCLES == 0) ? StIdle : StGap;
      end
      StGap: begin
        if (gap_cnt_q == GapLast) state_d = StIdle;
        else gap_cnt_d = gap_cnt_q + 4'd1;
      end
      default: state_d = StIdle;
    endcase
  end

  assign read_0 = rd_en && (gnt_q == 2'd0);
  assign read_1 = rd_en && (gnt_q == 2'd1);
  assign read_2 = rd_en && (gnt_q == 2'd2);
  assign read_3 = rd_en && (gnt_q == 2'd3);
  assign busy   = (state_q != StIdle);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      gnt_q     <= 2'd0;
      ptr_q     <= 2'd0;
      rd_cnt_q  <= 9'd0;
      gap_cnt_q <= 4'd0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      rd_cnt_q  <= rd_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // Return side: rd_q marks that port_sel holds a requested byte this cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_q      <= 1'b0;
      last_rd_q <= 1'b0;
      idx_q     <= 9'd0;
      len_q     <= 8'd0;
      out_data  <= 8'h00;
      out_valid <= 1'b0;
      out_sop   <= 1'b0;
      out_eop   <= 1'b0;
      out_port  <= 2'd0;
    end else begin
      rd_q      <= rd_en;
      last_rd_q <= rd_last;
      out_valid <= rd_q;
      out_sop   <= rd_q && (idx_q == 9'd0);
      out_eop   <= rd_q && last_rd_q;
      if (state_q == StIdle) idx_q <= 9'd0;
      else if (rd_q) idx_q <= idx_q + 9'd1;
      if (rd_q) begin
        out_data <= port_sel;
        if (idx_q == 9'd2) len_q <= port_sel;
        if (idx_q == 9'd0) out_port <= gnt_q;
      end
    end
  end

`ifdef DRAIN_FCS_CHK_EN
  logic [7:0] fcs_acc_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fcs_acc_q <= 8'h00;
      fcs_err   <= 1'b0;
    end else begin
      fcs_err <= rd_q && last_rd_q && (fcs_acc_q != port_sel);
      if (rd_q) fcs_acc_q <= (idx_q == 9'd0) ? port_sel : (fcs_acc_q ^ port_sel);
    end
  end
`endif

endmodule

// File: tb/tb_output_drain_arbiter.sv
// Bench for output_drain_arbiter: queue-based switch model and packet-level reference model.
module tb_output_drain_arbiter;
  localparam int unsigned GAP = 1;

  typedef struct packed {
    logic [7:0] data;
    logic       sop;
    logic       eop;
    logic [1:0] port;
    logic       err;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] port_v [4];
  logic [3:0] ready_v;
  logic       read_0, read_1, read_2, read_3;
  logic [7:0] out_data;
  logic       out_valid, out_sop, out_eop;
  logic [1:0] out_port;
  logic       busy;
  logic       fcs_err;

  output_drain_arbiter #(.GAP_CYCLES(GAP)) dut (
    .clk(clk), .reset(reset),
    .port0(port_v[0]), .port1(port_v[1]), .port2(port_v[2]), .port3(port_v[3]),
    .ready_0(ready_v[0]), .ready_1(ready_v[1]), .ready_2(ready_v[2]), .ready_3(ready_v[3]),
    .read_0(read_0), .read_1(read_1), .read_2(read_2), .read_3(read_3),
    .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop), .out_eop(out_eop),
    .out_port(out_port), .busy(busy)
`ifdef DRAIN_FCS_CHK_EN
    , .fcs_err(fcs_err)
`endif
  );
`ifndef DRAIN_FCS_CHK_EN
  assign fcs_err = 1'b0;
`endif

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc, onehot_viol, m_ptr;
  logic [7:0] pq [4][$];
  int pk_off [4][$];
  int pk_len [4][$];
  logic [7:0] pool[$];
  logic [3:0] rd_hist[$];
  logic busy_hist[$];
  beat_t beats[$], exp_beats[$];
  int beat_cyc[$];
  int exp_port[$], exp_len[$];
  int act_port[$], act_start[$], act_len[$];

  // One cycle: observe outputs at negedge, then play the switch just after the edge.
  task automatic tick();
    logic [3:0] rv;
    beat_t b;
    @(negedge clk);
    rv = {read_3, read_2, read_1, read_0};
    if ($countones(rv) > 1) onehot_viol++;
    rd_hist.push_back(rv);
    busy_hist.push_back(busy);
    if (out_valid) begin
      b = '{data: out_data, sop: out_sop, eop: out_eop, port: out_port, err: fcs_err};
      beats.push_back(b);
      beat_cyc.push_back(cyc);
    end
    cyc++;
    @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      if (rv[n]) begin
        if (pq[n].size() > 0) port_v[n] = pq[n].pop_front();
        else port_v[n] = 8'hEE;
      end
      ready_v[n] = (pq[n].size() != 0);
    end
  endtask

  task automatic clear_logs();
    rd_hist.delete(); busy_hist.delete(); beats.delete(); beat_cyc.delete();
    exp_beats.delete(); exp_port.delete(); exp_len.delete();
    act_port.delete(); act_start.delete(); act_len.delete();
    cyc = 0;
    onehot_viol = 0;
  endtask

  task automatic load_bytes(input int p, input logic [7:0] b[$]);
    pk_off[p].push_back(pool.size());
    pk_len[p].push_back(b.size());
    foreach (b[i]) begin
      pool.push_back(b[i]);
      pq[p].push_back(b[i]);
    end
    ready_v[p] = 1'b1;
  endtask

  task automatic rand_pkt(input int p, input int len);
    logic [7:0] b[$];
    logic [7:0] x;
    b.push_back(8'($urandom));
    b.push_back(8'($urandom));
    b.push_back(8'(len));
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    x = 8'h00;
    foreach (b[i]) x ^= b[i];
    if ($urandom_range(0, 1) == 1) b.push_back(x);
    else b.push_back(8'($urandom));
    load_bytes(p, b);
  endtask

  function automatic logic exp_err(input int off, input int len);
`ifdef DRAIN_FCS_CHK_EN
    logic [7:0] x;
    x = 8'h00;
    for (int k = 0; k < len - 1; k++) x ^= pool[off + k];
    return x != pool[off + len - 1];
`else
    return 1'b0;
`endif
  endfunction

  // Reference: serve pending packets round-robin from the pointer, one whole packet per grant.
  task automatic model_schedule();
    int p, off, len;
    beat_t b;
    p = 0;
    while (p >= 0) begin
      p = -1;
      for (int i = 0; i < 4; i++)
        if (p < 0 && pk_off[(m_ptr + i) % 4].size() > 0) p = (m_ptr + i) % 4;
      if (p >= 0) begin
        off = pk_off[p].pop_front();
        len = pk_len[p].pop_front();
        exp_port.push_back(p);
        exp_len.push_back(len);
        for (int k = 0; k < len; k++) begin
          b.data = pool[off + k];
          b.sop  = (k == 0);
          b.eop  = (k == len - 1);
          b.port = 2'(p);
          b.err  = (k == len - 1) ? exp_err(off, len) : 1'b0;
          exp_beats.push_back(b);
        end
        m_ptr = (p + 1) % 4;
      end
    end
  endtask

  task automatic extract_bursts();
    logic [3:0] prev;
    int lo;
    prev = 4'd0;
    for (int i = 0; i < rd_hist.size(); i++) begin
      if (rd_hist[i] != 4'd0) begin
        if (rd_hist[i] != prev) begin
          lo = 0;
          for (int j = 3; j >= 0; j--) if (rd_hist[i][j]) lo = j;
          act_port.push_back(lo);
          act_start.push_back(i);
          act_len.push_back(0);
        end
        act_len[act_len.size() - 1] = act_len[act_len.size() - 1] + 1;
      end
      prev = rd_hist[i];
    end
  endtask

  task automatic run_idle(input int max_cyc, output bit timeout);
    int n;
    bit done;
    n = 0;
    done = 0;
    while (!done && n < max_cyc) begin
      tick();
      n++;
      done = !busy && pq[0].size() == 0 && pq[1].size() == 0 &&
             pq[2].size() == 0 && pq[3].size() == 0;
    end
    timeout = !done;
    repeat (3) tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    n_checks++;
    if ({read_3, read_2, read_1, read_0} !== 4'b0) begin
      n_fail++; $display("FAIL reset_read act=%b exp=0000", {read_3, read_2, read_1, read_0});
    end
    n_checks++;
    if ({out_valid, out_sop, out_eop} !== 3'b0) begin
      n_fail++; $display("FAIL reset_flags act=%b exp=000", {out_valid, out_sop, out_eop});
    end
    n_checks++;
    if (out_data !== 8'h00) begin n_fail++; $display("FAIL reset_data act=%h exp=00", out_data); end
    n_checks++;
    if (out_port !== 2'd0) begin n_fail++; $display("FAIL reset_port act=%0d exp=0", out_port); end
    n_checks++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy act=%b exp=0", busy); end
    n_checks++;
    if (fcs_err !== 1'b0) begin n_fail++; $display("FAIL reset_fcs act=%b exp=0", fcs_err); end
    reset = 1'b1;
    repeat (2) tick();
    n_checks++;
    if (busy !== 1'b0 || rd_hist[rd_hist.size() - 1] !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset busy=%b exp=0", busy);
    end
  endtask

  task automatic test_round_robin();
    bit to;
    int last;
    clear_logs();
    rand_pkt(0, 2); rand_pkt(0, 2); rand_pkt(1, 2); rand_pkt(2, 2); rand_pkt(3, 2);
    run_idle(300, to);
    model_schedule();
    extract_bursts();
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rr_timeout act=busy exp=idle"); end
    n_checks++;
    if (onehot_viol != 0) begin n_fail++; $display("FAIL rr_onehot act=%0d exp=0", onehot_viol); end
    n_checks++;
    if (act_port.size() != exp_port.size()) begin
      n_fail++; $display("FAIL rr_bursts act=%0d exp=%0d", act_port.size(), exp_port.size());
    end
    for (int i = 0; i < exp_port.size() && i < act_port.size(); i++) begin
      n_checks++;
      if (act_port[i] != exp_port[i] || act_len[i] != exp_len[i]) begin
        n_fail++;
        $display("FAIL rr_grant %0d act=p%0d/%0d exp=p%0d/%0d", i, act_port[i], act_len[i],
                 exp_port[i], exp_len[i]);
      end
      if (i > 0) begin
        last = act_start[i - 1] + act_len[i - 1] - 1;
        n_checks++;
        if (act_start[i] - last < 3 + int'(GAP)) begin
          n_fail++;
          $display("FAIL rr_gap %0d act=%0d exp>=%0d", i, act_start[i] - last, 3 + int'(GAP));
        end
      end
    end
    n_checks++;
    if (beats.size() != exp_beats.size()) begin
      n_fail++; $display("FAIL rr_beats act=%0d exp=%0d", beats.size(), exp_beats.size());
    end
  endtask

  task automatic test_single();
    bit to;
    logic [7:0] b[$];
    int fall;
    clear_logs();
    b = '{8'h01, 8'h01, 8'h01, 8'h01, 8'h01};
    load_bytes(0, b);
    run_idle(60, to);
    model_schedule();
    extract_bursts();
    n_checks++;
    if (to) begin n_fail++; $display("FAIL single_timeout act=busy exp=idle"); end
    n_checks++;
    if (act_start.size() != 1 || act_start[0] != 1 || act_len[0] != 5 || act_port[0] != 0) begin
      n_fail++;
      $display("FAIL single_read bursts=%0d start=%0d len=%0d exp 1/1/5", act_start.size(),
               act_start.size() ? act_start[0] : -1, act_len.size() ? act_len[0] : -1);
    end
    n_checks++;
    if (beat_cyc.size() == 0 || beat_cyc[0] != 3) begin
      n_fail++; $display("FAIL single_sop_latency act=%0d exp=3",
                         beat_cyc.size() ? beat_cyc[0] : -1);
    end
    n_checks++;
    if (beats.size() != 5) begin n_fail++; $display("FAIL single_count act=%0d exp=5", beats.size()); end
    for (int i = 0; i < exp_beats.size(); i++) begin
      n_checks++;
      if (i >= beats.size() || beats[i] !== exp_beats[i]) begin
        n_fail++; $display("FAIL single_beat %0d act=%h exp=%h", i,
                           (i < beats.size()) ? beats[i] : '1, exp_beats[i]);
      end
    end
    fall = 1 + 5 - 1 + 2 + int'(GAP);
    n_checks++;
    if ({busy_hist[0], busy_hist[1], busy_hist[fall - 1], busy_hist[fall]} !== 4'b0110) begin
      n_fail++;
      $display("FAIL single_busy act=%b exp=0110",
               {busy_hist[0], busy_hist[1], busy_hist[fall - 1], busy_hist[fall]});
    end
  endtask

  task automatic test_len_edge(input int p, input int len, input int max_cyc);
    bit to;
    clear_logs();
    rand_pkt(p, len);
    run_idle(max_cyc, to);
    model_schedule();
    extract_bursts();
    n_checks++;
    if (to) begin n_fail++; $display("FAIL len%0d_timeout act=busy exp=idle", len); end
    n_checks++;
    if (act_len.size() != 1 || act_len[0] != len + 4 || act_port[0] != p) begin
      n_fail++;
      $display("FAIL len%0d_reads bursts=%0d len=%0d exp 1/%0d port %0d", len, act_len.size(),
               act_len.size() ? act_len[0] : -1, len + 4, p);
    end
    n_checks++;
    if (beats.size() != len + 4) begin
      n_fail++; $display("FAIL len%0d_count act=%0d exp=%0d", len, beats.size(), len + 4);
    end
    for (int i = 0; i < exp_beats.size(); i++) begin
      n_checks++;
      if (i >= beats.size() || beats[i] !== exp_beats[i]) begin
        n_fail++; $display("FAIL len%0d_beat %0d act=%h exp=%h", len, i,
                           (i < beats.size()) ? beats[i] : '1, exp_beats[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int nrd, eops;
    clear_logs();
    rand_pkt(1, 6);
    nrd = 0;
    for (int i = 0; i < 30 && nrd < 6; i++) begin
      tick();
      if (rd_hist[rd_hist.size() - 1][1]) nrd++;
    end
    n_checks++;
    if (nrd != 6 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_reach act=%0d reads busy=%b exp=6 reads busy=1", nrd, busy);
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({read_3, read_2, read_1, read_0, out_valid, out_sop, out_eop, out_port, busy, fcs_err}
        !== 13'd0 || out_data !== 8'h00) begin
      n_fail++;
      $display("FAIL rstmid_clear act=%b data=%h exp all zero",
               {read_3, read_2, read_1, read_0, out_valid, out_sop, out_eop, out_port, busy,
                fcs_err}, out_data);
    end
    repeat (2) tick();
    eops = 0;
    foreach (beats[i]) if (beats[i].eop) eops++;
    n_checks++;
    if (eops != 0) begin n_fail++; $display("FAIL rstmid_eop act=%0d exp=0", eops); end
    for (int n = 0; n < 4; n++) begin
      pq[n].delete(); pk_off[n].delete(); pk_len[n].delete();
    end
    ready_v = 4'b0;
    m_ptr = 0;
    reset = 1'b1;
    clear_logs();
    rand_pkt(3, 3);
    rand_pkt(1, 2);
    run_idle(100, to);
    model_schedule();
    extract_bursts();
    n_checks++;
    if (to) begin n_fail++; $display("FAIL rstmid_timeout act=busy exp=idle"); end
    n_checks++;
    if (act_port.size() != 2 || act_port[0] != exp_port[0] || act_port[1] != exp_port[1]) begin
      n_fail++;
      $display("FAIL rstmid_order act=%0d first=%0d exp=2 first=%0d", act_port.size(),
               act_port.size() ? act_port[0] : -1, exp_port[0]);
    end
    for (int i = 0; i < exp_beats.size(); i++) begin
      n_checks++;
      if (i >= beats.size() || beats[i] !== exp_beats[i]) begin
        n_fail++; $display("FAIL rstmid_beat %0d act=%h exp=%h", i,
                           (i < beats.size()) ? beats[i] : '1, exp_beats[i]);
      end
    end
  endtask

  task automatic test_fcs_good();
    bit to;
    logic [7:0] b[$];
    clear_logs();
    b = '{8'h0A, 8'h05, 8'h01, 8'hF0, 8'hFE};
    load_bytes(2, b);
    run_idle(60, to);
    model_schedule();
    n_checks++;
    if (to || beats.size() != 5) begin
      n_fail++; $display("FAIL fcs_good_count act=%0d exp=5", beats.size());
    end
    n_checks++;
    if (beats.size() != 5 || beats[4] !== exp_beats[4] || beats[4].err !== 1'b0) begin
      n_fail++; $display("FAIL fcs_good_eop act=%h exp=%h",
                         beats.size() ? beats[beats.size() - 1] : '1, exp_beats[4]);
    end
  endtask

  task automatic test_random();
    bit to;
    int np, last;
    for (int r = 0; r < 6; r++) begin
      clear_logs();
      np = 0;
      for (int p = 0; p < 4; p++) begin
        for (int k = $urandom_range(0, 2); k > 0; k--) begin
          rand_pkt(p, $urandom_range(0, 12));
          np++;
        end
      end
      if (np == 0) rand_pkt($urandom_range(0, 3), $urandom_range(0, 12));
      run_idle(1500, to);
      model_schedule();
      extract_bursts();
      n_checks++;
      if (to || onehot_viol != 0) begin
        n_fail++; $display("FAIL rand%0d_run timeout=%0d onehot=%0d exp 0/0", r, to, onehot_viol);
      end
      n_checks++;
      if (act_port.size() != exp_port.size()) begin
        n_fail++;
        $display("FAIL rand%0d_bursts act=%0d exp=%0d", r, act_port.size(), exp_port.size());
      end
      for (int i = 0; i < exp_port.size() && i < act_port.size(); i++) begin
        n_checks++;
        if (act_port[i] != exp_port[i] || act_len[i] != exp_len[i]) begin
          n_fail++;
          $display("FAIL rand%0d_grant %0d act=p%0d/%0d exp=p%0d/%0d", r, i, act_port[i],
                   act_len[i], exp_port[i], exp_len[i]);
        end
        if (i > 0) begin
          last = act_start[i - 1] + act_len[i - 1] - 1;
          n_checks++;
          if (act_start[i] - last < 3 + int'(GAP)) begin
            n_fail++; $display("FAIL rand%0d_gap %0d act=%0d exp>=%0d", r, i,
                               act_start[i] - last, 3 + int'(GAP));
          end
        end
      end
      for (int i = 0; i < exp_beats.size(); i++) begin
        n_checks++;
        if (i >= beats.size() || beats[i] !== exp_beats[i]) begin
          n_fail++; $display("FAIL rand%0d_beat %0d act=%h exp=%h", r, i,
                             (i < beats.size()) ? beats[i] : '1, exp_beats[i]);
        end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    reset = 1'b0;
    ready_v = 4'b0;
    for (int n = 0; n < 4; n++) port_v[n] = 8'h00;
    m_ptr = 0;
    clear_logs();
    test_reset();
    test_round_robin();
    test_single();
    test_len_edge(3, 255, 400);
    test_len_edge(2, 0, 60);
    test_reset_mid();
    test_fcs_good();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
